// File: rtl/imm_instr_encoder.sv
// Immediate instruction encoder: packs opcode/fields/immediate into a 16-bit word and streams it to IMEM.
// Optional build macro IMM_ENC_SATURATE_EN clamps out-of-range immediates instead of dropping them.
`timescale 1ns/1ps
module imm_instr_encoder #(
  parameter int ADDR_W   = 8,
  parameter int PROG_LEN = 256
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_start,
  input  logic [ADDR_W-1:0] i_base_addr,
  input  logic              i_in_valid,
  output logic              o_in_ready,
  input  logic [3:0]        i_opcode,
  input  logic [1:0]        i_imm_src,
  input  logic [15:0]       i_base_fields,
  input  logic [7:0]        i_imm_in,
  output logic              o_out_valid,
  input  logic              i_out_ready,
  output logic [ADDR_W-1:0] o_imem_addr,
  output logic [15:0]       o_imem_wdata,
  output logic              o_out_last,
  output logic              o_err,
  output logic [7:0]        o_err_count
);

  localparam logic [ADDR_W-1:0] LAST_CNT = ADDR_W'(PROG_LEN - 1);

  // Handshakes: a transfer happens on a clock edge where valid && ready are both high;
  // valid never depends on ready, and payload is held stable while valid && !ready.
  logic              r_s1_valid;
  logic [15:0]       r_s1_word;
  logic              r_out_valid;
  logic [ADDR_W-1:0] r_imem_addr;
  logic [15:0]       r_imem_wdata;
  logic              r_out_last;
  logic              r_err;
  logic [7:0]        r_err_count;
  logic [ADDR_W-1:0] r_next_addr;
  logic [ADDR_W-1:0] r_base;
  logic [ADDR_W-1:0] r_cnt;

  logic signed [7:0] w_imm_s;
  logic [5:0]        w_field;
  logic [15:0]       w_word;
  logic              w_class_err;
  logic              w_range_err;
  logic              w_emit;
  logic              w_count_err;
  logic              w_s2_free;
  logic              w_s1_move;
  logic              w_accept;

  assign w_imm_s = i_imm_in;

  always_comb begin
    w_word        = i_base_fields;
    w_word[15:12] = i_opcode;
    w_field       = i_imm_in[5:0];
    w_class_err   = 1'b0;
    w_range_err   = 1'b0;
    case (i_imm_src)
      2'b00: begin
        if (i_opcode == 4'b1010)      w_word[8:1]  = i_imm_in;
        else if (i_opcode == 4'b1101) w_word[11:4] = i_imm_in;
        else                          w_class_err  = 1'b1;
      end
      2'b01: begin
        if (w_imm_s < 8'sd0) begin
          w_range_err = 1'b1;
          w_field     = 6'd0;
        end else if (w_imm_s > 8'sd63) begin
          w_range_err = 1'b1;
          w_field     = 6'd63;
        end
        w_word[5:0] = w_field;
      end
      2'b10: begin
        if (w_imm_s < 8'sd0) begin
          w_range_err = 1'b1;
          w_field     = 6'd0;
        end else if (w_imm_s > 8'sd7) begin
          w_range_err = 1'b1;
          w_field     = 6'd7;
        end
        w_word[5:3] = w_field[2:0];
      end
      default: begin
        if (w_imm_s < -8'sd16) begin
          w_range_err = 1'b1;
          w_field     = 6'b010000;
        end else if (w_imm_s > 8'sd15) begin
          w_range_err = 1'b1;
          w_field     = 6'b001111;
        end
        w_word[5:1] = w_field[4:0];
      end
    endcase
  end

`ifdef IMM_ENC_SATURATE_EN
  assign w_emit      = !w_class_err;
  assign w_count_err = w_class_err;
`else
  assign w_emit      = !w_class_err && !w_range_err;
  assign w_count_err = w_class_err || w_range_err;
`endif

  assign w_s2_free  = !r_out_valid || i_out_ready;
  assign w_s1_move  = r_s1_valid && w_s2_free && !i_start;
  assign o_in_ready = !i_start && (!r_s1_valid || w_s2_free);
  assign w_accept   = i_in_valid && o_in_ready;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_s1_valid   <= 1'b0;
      r_s1_word    <= '0;
      r_out_valid  <= 1'b0;
      r_imem_addr  <= '0;
      r_imem_wdata <= '0;
      r_out_last   <= 1'b0;
      r_err        <= 1'b0;
      r_err_count  <= '0;
      r_next_addr  <= '0;
      r_base       <= '0;
      r_cnt        <= '0;
    end else begin
      // Illegal requests are consumed here and never occupy S1.
      if (w_accept) begin
        r_s1_valid <= w_emit;
        r_s1_word  <= w_word;
        if (w_class_err || w_range_err) r_err <= 1'b1;
        if (w_count_err && r_err_count != 8'hFF) r_err_count <= r_err_count + 8'd1;
      end else if (w_s1_move || i_start) begin
        r_s1_valid <= 1'b0;
      end

      if (w_s1_move) begin
        r_out_valid  <= 1'b1;
        r_imem_addr  <= r_next_addr;
        r_imem_wdata <= r_s1_word;
        r_out_last   <= (r_cnt == LAST_CNT);
        if (r_cnt == LAST_CNT) begin
          r_cnt       <= '0;
          r_next_addr <= r_base;
        end else begin
          r_cnt       <= r_cnt + ADDR_W'(1);
          r_next_addr <= r_next_addr + ADDR_W'(1);
        end
      end else if (i_out_ready) begin
        r_out_valid <= 1'b0;
      end

      // A pending S2 word keeps its address; the new base applies to the next word.
      if (i_start) begin
        r_base      <= i_base_addr;
        r_next_addr <= i_base_addr;
        r_cnt       <= '0;
        r_err       <= 1'b0;
        r_err_count <= '0;
      end
    end
  end

  assign o_out_valid  = r_out_valid;
  assign o_imem_addr  = r_imem_addr;
  assign o_imem_wdata = r_imem_wdata;
  assign o_out_last   = r_out_last;
  assign o_err        = r_err;
  assign o_err_count  = r_err_count;

endmodule

// File: tb/tb_imm_instr_encoder.sv
// Bench for imm_instr_encoder (PROG_LEN=4 so address wrap and reload are exercised quickly).
`timescale 1ns/1ps
module tb_imm_instr_encoder;
  localparam int ADDR_W   = 8;
  localparam int PROG_LEN = 4;

  logic              clk = 1'b0;
  logic              i_rst_n = 1'b0;
  logic              i_start = 1'b0;
  logic [ADDR_W-1:0] i_base_addr = '0;
  logic              i_in_valid = 1'b0;
  logic              o_in_ready;
  logic [3:0]        i_opcode = '0;
  logic [1:0]        i_imm_src = '0;
  logic [15:0]       i_base_fields = '0;
  logic [7:0]        i_imm_in = '0;
  logic              o_out_valid;
  logic              i_out_ready = 1'b1;
  logic [ADDR_W-1:0] o_imem_addr;
  logic [15:0]       o_imem_wdata;
  logic              o_out_last;
  logic              o_err;
  logic [7:0]        o_err_count;

  imm_instr_encoder #(.ADDR_W(ADDR_W), .PROG_LEN(PROG_LEN)) dut (
    .i_clk(clk), .i_rst_n(i_rst_n), .i_start(i_start), .i_base_addr(i_base_addr),
    .i_in_valid(i_in_valid), .o_in_ready(o_in_ready), .i_opcode(i_opcode),
    .i_imm_src(i_imm_src), .i_base_fields(i_base_fields), .i_imm_in(i_imm_in),
    .o_out_valid(o_out_valid), .i_out_ready(i_out_ready), .o_imem_addr(o_imem_addr),
    .o_imem_wdata(o_imem_wdata), .o_out_last(o_out_last), .o_err(o_err),
    .o_err_count(o_err_count)
  );

  // clock / reset
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // reference model: {emit, bad, word}
  function automatic logic [17:0] model_enc(input logic [3:0] op, input logic [1:0] src,
                                            input logic [15:0] bf, input logic [7:0] imm);
    logic [15:0] w;
    int v, lo, hi;
    logic emit, bad;
    w = {op, bf[11:0]};
    v = $signed(imm);
    emit = 1'b1;
    bad = 1'b0;
    lo = 0;
    hi = 0;
    if (src == 2'd0) begin
      if (op == 4'hA)      w[8:1]  = imm;
      else if (op == 4'hD) w[11:4] = imm;
      else begin emit = 1'b0; bad = 1'b1; end
    end else begin
      case (src)
        2'd1:    begin lo = 0;   hi = 63; end
        2'd2:    begin lo = 0;   hi = 7;  end
        default: begin lo = -16; hi = 15; end
      endcase
      if (v < lo || v > hi) begin
        bad = 1'b1;
`ifdef IMM_ENC_SATURATE_EN
        v = (v < lo) ? lo : hi;
`else
        emit = 1'b0;
`endif
      end
      case (src)
        2'd1:    w[5:0] = v[5:0];
        2'd2:    w[5:3] = v[2:0];
        default: w[5:1] = v[4:0];
      endcase
    end
    return {emit, bad, w};
  endfunction

  // scoreboard: {addr, last, word}
  logic [ADDR_W+16:0] exp_q[$];
  logic [ADDR_W-1:0]  m_addr = '0, m_base = '0, m_cnt = '0;
  logic               m_err = 1'b0;
  logic [7:0]         m_errc = '0;
  logic               hold_chk = 1'b0;
  logic [ADDR_W-1:0]  hold_addr;
  logic [15:0]        hold_data;
  logic               hold_last;

  // Monitor samples on the falling edge; inputs change just after the rising edge.
  // start is only issued with the pipeline drained, so S1 flushes never drop queued items.
  always @(negedge clk) begin
    logic [17:0]        r;
    logic [ADDR_W+16:0] e;
    if (!i_rst_n) begin
      exp_q.delete();
      m_addr = '0; m_base = '0; m_cnt = '0; m_err = 1'b0; m_errc = '0;
      hold_chk = 1'b0;
    end else begin
      if (hold_chk) begin
        check("hold_addr", 32'(o_imem_addr), 32'(hold_addr));
        check("hold_data", 32'(o_imem_wdata), 32'(hold_data));
        check("hold_last", 32'(o_out_last), 32'(hold_last));
      end
      if (o_out_valid && i_out_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_out", 32'(o_imem_wdata), 32'hFFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          check("addr", 32'(o_imem_addr), 32'(e[ADDR_W+16:17]));
          check("last", 32'(o_out_last), 32'(e[16]));
          check("data", 32'(o_imem_wdata), 32'(e[15:0]));
        end
      end
      hold_chk  = o_out_valid && !i_out_ready;
      hold_addr = o_imem_addr;
      hold_data = o_imem_wdata;
      hold_last = o_out_last;
      if (i_start) begin
        m_base = i_base_addr; m_addr = i_base_addr; m_cnt = '0;
        m_err = 1'b0; m_errc = '0;
      end else if (i_in_valid && o_in_ready) begin
        r = model_enc(i_opcode, i_imm_src, i_base_fields, i_imm_in);
        if (r[16]) m_err = 1'b1;
        if (r[16] && !r[17] && m_errc != 8'hFF) m_errc = m_errc + 8'd1;
        if (r[17]) begin
          exp_q.push_back({m_addr, (m_cnt == ADDR_W'(PROG_LEN - 1)), r[15:0]});
          if (m_cnt == ADDR_W'(PROG_LEN - 1)) begin
            m_cnt = '0; m_addr = m_base;
          end else begin
            m_cnt = m_cnt + 1'b1; m_addr = m_addr + 1'b1;
          end
        end
      end
    end
  end

  // driver tasks
  task automatic send(input logic [3:0] op, input logic [1:0] src,
                      input logic [15:0] bf, input logic [7:0] imm);
    bit done;
    done = 1'b0;
    i_opcode = op; i_imm_src = src; i_base_fields = bf; i_imm_in = imm;
    i_in_valid = 1'b1;
    for (int n = 0; n < 200 && !done; n++) begin
      @(negedge clk);
      done = o_in_ready;
      @(posedge clk); #1;
    end
    i_in_valid = 1'b0;
    if (!done) check("send_timeout", 32'd0, 32'd1);
  endtask

  task automatic do_start(input logic [ADDR_W-1:0] base);
    i_start = 1'b1; i_base_addr = base;
    @(posedge clk); #1;
    i_start = 1'b0;
  endtask

  task automatic drain();
    bit done;
    done = 1'b0;
    for (int n = 0; n < 500 && !done; n++) begin
      @(negedge clk);
      done = (exp_q.size() == 0) && !o_out_valid;
    end
    if (!done) check("drain_timeout", 32'(exp_q.size()), 32'd0);
    @(posedge clk); #1;
  endtask

  task automatic check_err();
    @(negedge clk);
    check("err", 32'(o_err), 32'(m_err));
    check("err_count", 32'(o_err_count), 32'(m_errc));
    @(posedge clk); #1;
  endtask

  bit burst_done;

  initial begin
    repeat (3) @(posedge clk);
    #1 i_rst_n = 1'b1;
    @(negedge clk);
    check("rst_out_valid", 32'(o_out_valid), 32'd0);
    check("rst_addr", 32'(o_imem_addr), 32'd0);
    check("rst_wdata", 32'(o_imem_wdata), 32'd0);
    check("rst_last", 32'(o_out_last), 32'd0);
    check("rst_err", 32'(o_err), 32'd0);
    check("rst_err_count", 32'(o_err_count), 32'd0);
    check("rst_in_ready", 32'(o_in_ready), 32'd1);
    @(posedge clk); #1;

    // LDI with two-cycle latency
    do_start(8'h10);
    send(4'hA, 2'd0, 16'h0000, 8'hA5);
    @(negedge clk);
    check("lat1_valid", 32'(o_out_valid), 32'd0);
    @(negedge clk);
    check("lat2_valid", 32'(o_out_valid), 32'd1);
    check("ldi_word", 32'(o_imem_wdata), 32'hA14A);
    check("ldi_addr", 32'(o_imem_addr), 32'h10);
    @(posedge clk); #1;
    drain();

    // back-to-back JMP then ADDI, no bubbles
    do_start(8'h10);
    send(4'hD, 2'd0, 16'h0000, 8'h3C);
    send(4'h1, 2'd3, 16'h0000, 8'hFD);
    @(negedge clk);
    check("b2b_valid0", 32'(o_out_valid), 32'd1);
    check("jmp_word", 32'(o_imem_wdata), 32'hD3C0);
    @(negedge clk);
    check("b2b_valid1", 32'(o_out_valid), 32'd1);
    check("addi_word", 32'(o_imem_wdata), 32'h103A);
    check("addi_addr", 32'(o_imem_addr), 32'h11);
    @(posedge clk); #1;
    drain();

    // SHIFT out of range, class error, then a legal word to confirm the address
    do_start(8'h40);
    send(4'h7, 2'd2, 16'h0ABC, 8'd9);
    drain();
    check_err();
    send(4'h3, 2'd0, 16'h0000, 8'h11);
    send(4'h5, 2'd1, 16'h0F00, 8'd63);
    drain();
    check_err();

    // backpressure: three queued requests while the writer stalls
    do_start(8'h80);
    i_out_ready = 1'b0;
    fork
      begin
        send(4'hA, 2'd0, 16'h0000, 8'h01);
        send(4'h2, 2'd1, 16'h0123, 8'd5);
        send(4'h4, 2'd2, 16'h0FFF, 8'd3);
      end
      begin
        repeat (5) @(negedge clk);
        check("bp_in_ready", 32'(o_in_ready), 32'd0);
        check("bp_out_valid", 32'(o_out_valid), 32'd1);
        @(posedge clk); #1;
        i_out_ready = 1'b1;
      end
    join
    drain();

    // address wrap with program-length reload
    do_start(8'hFE);
    for (int i = 0; i < 5; i++) send(4'hA, 2'd0, 16'h0000, 8'(i * 17));
    drain();

    // randomized burst with random writer stalls
    do_start(8'h30);
    burst_done = 1'b0;
    fork
      begin
        for (int i = 0; i < 40; i++)
          send(4'($urandom_range(0, 15)), 2'($urandom_range(0, 3)),
               16'($urandom_range(0, 65535)), 8'($urandom_range(0, 255)));
        burst_done = 1'b1;
      end
      begin
        while (!burst_done) begin
          @(posedge clk); #1;
          i_out_ready = 1'($urandom_range(0, 1));
        end
        i_out_ready = 1'b1;
      end
    join
    drain();
    check_err();

    // reset while a word is pending
    do_start(8'h20);
    send(4'h0, 2'd0, 16'h0000, 8'h00);
    i_out_ready = 1'b0;
    send(4'hA, 2'd0, 16'h0000, 8'h77);
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    check("pre_rst_valid", 32'(o_out_valid), 32'd1);
    check("pre_rst_err_count", 32'(o_err_count), 32'(m_errc));
    @(posedge clk); #1;
    i_rst_n = 1'b0;
    @(posedge clk); #1;
    i_rst_n = 1'b1;
    i_out_ready = 1'b1;
    @(negedge clk);
    check("post_rst_valid", 32'(o_out_valid), 32'd0);
    check("post_rst_err_count", 32'(o_err_count), 32'd0);
    check("post_rst_addr", 32'(o_imem_addr), 32'd0);
    check("post_rst_err", 32'(o_err), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/imm_instr_encoder.md
Name: imm_instr_encoder

Overview:
- Inverse of the decode-side immediate extraction: packs opcode, non-immediate fields and an 8-bit immediate into a 16-bit instruction word.
- Range-checks the immediate against its immediate class.
- Streams encoded words to the instruction-memory write port with an auto-incrementing address.
- Sits between the boot/program loader and IMEM.

Parameters:
- ADDR_W, 8, IMEM address width.
- PROG_LEN, 256, words per program (1..2^ADDR_W); sets the last-address flag.

Ports:
- clk  input  1  clock.
- rst_n  input  1  synchronous active-low reset.
- start  input  1  pulse: load base address, clear error state.
- base_addr  input  ADDR_W  first IMEM address for the program.
- in_valid  input  1  encode request valid.
- in_ready  output  1  encoder can accept a request.
- opcode  input  4  instruction[15:12].
- imm_src  input  2  immediate class (00 LDI/JMP, 01 LOAD/STORE/BEQ/BNE, 10 SHIFT, 11 ADDI).
- base_fields  input  16  register/function bits; bits [15:12] and immediate bits are overwritten.
- imm_in  input  8  signed immediate.
- out_valid  output  1  encoded word valid.
- out_ready  input  1  IMEM writer accepts.
- imem_addr  output  ADDR_W  write address.
- imem_wdata  output  16  encoded word.
- out_last  output  1  word is at offset PROG_LEN-1 from base_addr.
- err  output  1  sticky range/class error.
- err_count  output  8  count of rejected requests, saturating at 255.

Behaviour:
- Reset (rst_n=0 at clk edge):
  - out_valid=0, imem_addr=0, imem_wdata=0, out_last=0, err=0, err_count=0.
  - Internal word counter=0, stage-1 register empty.
  - Reset mid-transfer discards both stages.
- Two-stage pipeline: S1 encode/check register, S2 output register.
  - in_ready = S1 empty, or S1 advances this cycle (S2 empty or out_ready=1).
  - Latency 2 cycles from accepted request to out_valid with no backpressure.
  - Full throughput: 1 word/cycle.
- Encoding. word[15:12]=opcode; other bits from base_fields except the immediate field:
  - imm_src=00, opcode=1010 (LDI): word[8:1]=imm_in[7:0]; any value legal.
  - imm_src=00, opcode=1101 (JMP): word[11:4]=imm_in[7:0]; any value legal.
  - imm_src=00, any other opcode: class error.
  - imm_src=01: word[5:0]=imm_in[5:0]; legal range 0..63.
  - imm_src=10: word[5:3]=imm_in[2:0]; legal range 0..7.
  - imm_src=11: word[5:1]=imm_in[4:0]; legal range -16..15 (two's complement).
- Error handling: an illegal request is consumed (handshake completes), no word is emitted, err set, err_count+1. Address does not advance.
- Output handshake: the word transfers when out_valid && out_ready. imem_addr, imem_wdata and out_last are held stable while out_valid && !out_ready.
- Addressing:
  - Each transferred word increments imem_addr modulo 2^ADDR_W, wrapping to 0.
  - out_last=1 when word counter == PROG_LEN-1; after that transfer the counter returns to 0 and imem_addr reloads base_addr.
- start:
  - Flushes the S1 stage.
  - Loads imem_addr=base_addr, counter=0, clears err and err_count.
  - If a word is pending (S2 out_valid=1), its address and data are preserved; the new base applies from the next word.
  - start has priority over a same-cycle in_valid (in_ready=0 that cycle).

Optional Feature:
- Macro IMM_ENC_SATURATE_EN.
- Defined:
  - Out-of-range immediates in classes 01/10/11 are clamped to the nearest legal bound and the word is emitted.
  - err is still set; err_count is not incremented.
  - Class errors (imm_src=00, bad opcode) are still dropped and counted.
- Not defined: drop-and-count as above.

Test Plan:
- Reset, start base_addr=0x10, LDI opcode=1010, imm_in=0xA5, base_fields=0 -> after 2 cycles out_valid=1, imem_addr=0x10, imem_wdata=0xA14A.
- Back-to-back JMP imm=0x3C, then ADDI opcode=0001 imm=-3, out_ready=1 -> words 0xD3C0 then 0x103A at 0x10, 0x11; no bubbles.
- SHIFT imm=9 -> no word, err=1, err_count=1, address unchanged.
  - With IMM_ENC_SATURATE_EN: word[5:3]=111, err=1, err_count=0.
- out_ready=0 for 5 cycles with 3 queued requests -> in_ready drops after S1 and S2 fill; outputs stable; all 3 words delivered in order once released.
- PROG_LEN=4, base_addr=0xFE, 5 words -> addresses FE, FF, 00, 01, then FE; out_last=1 on the 4th word only.
- rst_n=0 while out_valid=1 -> next cycle out_valid=0, err_count=0, imem_addr=0.
